// File: rtl/framebuffer_overlay.sv
// framebuffer_overlay: upscaled indexed-colour bitmap composited onto VGA RGB.
// Three-stage pixel path, palette lookup, write handshake and clear engine.
module framebuffer_overlay #(
   parameter int PIX_BITS    = 2,
   parameter int FB_W        = 160,
   parameter int FB_H        = 120,
   parameter int SCALE_SHIFT = 2,
   parameter int X_START     = 144,
   parameter int Y_START     = 35,
   parameter int AW          = $clog2(FB_W * FB_H)
) (
   input  logic                VGA_CLK,
   input  logic                RESET,
   input  logic [12:0]         H_CNT,
   input  logic [12:0]         V_CNT,
   input  logic [7:0]          VGA_R_IN,
   input  logic [7:0]          VGA_G_IN,
   input  logic [7:0]          VGA_B_IN,
   input  logic                WR_EN,
   input  logic [AW-1:0]       WR_ADDR,
   input  logic [PIX_BITS-1:0] WR_DATA,
   output logic                WR_READY,
   input  logic                PAL_WE,
   input  logic [PIX_BITS-1:0] PAL_IDX,
   input  logic [23:0]         PAL_DATA,
   input  logic                CLEAR_START,
   output logic                CLEAR_BUSY,
   output logic                CLEAR_DONE,
   output logic [7:0]          VGA_R_OUT,
   output logic [7:0]          VGA_G_OUT,
   output logic [7:0]          VGA_B_OUT
);

   localparam int            DEPTH = FB_W * FB_H;
   localparam int            NPAL  = 1 << PIX_BITS;
   localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
   localparam logic [12:0]   X0    = 13'(X_START);
   localparam logic [12:0]   Y0    = 13'(Y_START);
   localparam logic [12:0]   WIN_W = 13'(FB_W << SCALE_SHIFT);
   localparam logic [12:0]   WIN_H = 13'(FB_H << SCALE_SHIFT);

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      DONE
   } state_t;

   state_t        state;
   state_t        state_n;
   logic [AW-1:0] clr_cnt;
   logic          busy;
   logic          done;

   always_ff @(posedge VGA_CLK or posedge RESET) begin
      if (RESET) begin
         state   <= IDLE;
         clr_cnt <= '0;
      end else begin
         state   <= state_n;
         clr_cnt <= (state == CLEAR && clr_cnt != LAST) ? clr_cnt + 1'b1 : '0;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (CLEAR_START) state_n = CLEAR;
         CLEAR:   if (clr_cnt == LAST) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == CLEAR);
      done = (state == DONE);
   end

   assign CLEAR_BUSY = busy;
   assign CLEAR_DONE = done;
   assign WR_READY   = !busy;

   // The clear engine owns the single write port while it runs
   logic                wr_hit;
   logic                ram_we;
   logic [AW-1:0]       ram_wa;
   logic [PIX_BITS-1:0] ram_wd;

   assign wr_hit = WR_EN && !busy && (32'(WR_ADDR) < DEPTH);
   assign ram_we = busy || wr_hit;
   assign ram_wa = busy ? clr_cnt : WR_ADDR;
   assign ram_wd = busy ? '0 : WR_DATA;

   logic [12:0]   dx;
   logic [12:0]   dy;
   logic          win_n;
   logic [AW-1:0] addr_n;

   assign dx     = H_CNT - X0;
   assign dy     = V_CNT - Y0;
   assign win_n  = (H_CNT >= X0) && (dx < WIN_W) && (V_CNT >= Y0) && (dy < WIN_H);
   assign addr_n = AW'(32'(dx >> SCALE_SHIFT) + 32'(dy >> SCALE_SHIFT) * FB_W);

   logic                ram [DEPTH];
   logic [PIX_BITS-1:0] ram_q [DEPTH];
   logic [AW-1:0]       rd_addr;
   logic [PIX_BITS-1:0] idx2;

   // Read-before-write falls out of the non-blocking read of the old word
   always_ff @(posedge VGA_CLK) begin
      if (ram_we) ram_q[ram_wa] <= ram_wd;
      idx2 <= ram_q[rd_addr];
   end

   logic        win1;
   logic        win2;
   logic [23:0] rgb1;
   logic [23:0] rgb2;
   logic [23:0] rgb_out;
   logic [23:0] pal [NPAL];

   always_ff @(posedge VGA_CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < NPAL; i++)
            pal[i] <= (i == 0) ? 24'h0 : 24'hFF00FF;
      end else if (PAL_WE) begin
         pal[PAL_IDX] <= PAL_DATA;
      end
   end

   always_ff @(posedge VGA_CLK or posedge RESET) begin
      if (RESET) begin
         win1    <= 1'b0;
         win2    <= 1'b0;
         rd_addr <= '0;
         rgb1    <= '0;
         rgb2    <= '0;
         rgb_out <= '0;
      end else begin
         win1    <= win_n;
         rd_addr <= addr_n;
         rgb1    <= {VGA_R_IN, VGA_G_IN, VGA_B_IN};
         win2    <= win1;
         rgb2    <= rgb1;
         if (win2 && idx2 != '0) rgb_out <= pal[idx2];
         else                    rgb_out <= rgb2;
      end
   end

   assign {VGA_R_OUT, VGA_G_OUT, VGA_B_OUT} = rgb_out;

endmodule

// File: tb/tb_framebuffer_overlay.sv
// tb_framebuffer_overlay: random pixel/write/palette traffic against a
// geometric reference model, plus clear-engine and reset-abort scenarios.
module tb_framebuffer_overlay;

   localparam int FB_W  = 160;
   localparam int FB_H  = 120;
   localparam int DEPTH = FB_W * FB_H;
   localparam int AW    = 15;
   localparam int X0    = 144;
   localparam int Y0    = 35;

   logic          clk = 1'b0;
   logic          rst;
   logic [12:0]   h_cnt, v_cnt;
   logic [7:0]    r_in, g_in, b_in;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [1:0]    wr_data;
   logic          wr_ready;
   logic          pal_we;
   logic [1:0]    pal_idx;
   logic [23:0]   pal_data;
   logic          clr_start;
   logic          clr_busy;
   logic          clr_done;
   logic [7:0]    r_out, g_out, b_out;

   always #5 clk = ~clk;

   framebuffer_overlay dut (
      .VGA_CLK(clk), .RESET(rst),
      .H_CNT(h_cnt), .V_CNT(v_cnt),
      .VGA_R_IN(r_in), .VGA_G_IN(g_in), .VGA_B_IN(b_in),
      .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
      .WR_READY(wr_ready),
      .PAL_WE(pal_we), .PAL_IDX(pal_idx), .PAL_DATA(pal_data),
      .CLEAR_START(clr_start), .CLEAR_BUSY(clr_busy), .CLEAR_DONE(clr_done),
      .VGA_R_OUT(r_out), .VGA_G_OUT(g_out), .VGA_B_OUT(b_out)
   );

   int checks = 0;
   int failures = 0;

   int          fb_m [DEPTH];
   logic [23:0] pal_m [4];

   typedef struct {
      logic [23:0] e;
      bit          care;
      int          h;
      int          v;
   } exp_t;

   exp_t exp_q[$];

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t model_px(int h, int v, logic [23:0] rgb);
      exp_t x;
      int dx, dy, idx;
      x.h = h;
      x.v = v;
      x.e = rgb;
      x.care = 1'b1;
      dx = h - X0;
      dy = v - Y0;
      if (dx < 0 || dy < 0 || dx >= FB_W * 4 || dy >= FB_H * 4) return x;
      idx = fb_m[dx / 4 + (dy / 4) * FB_W];
      if (idx < 0) x.care = 1'b0;
      else if (idx != 0) x.e = pal_m[idx];
      return x;
   endfunction

   task automatic pix(int h, int v, logic [23:0] rgb);
      exp_t x;
      tick();
      if (exp_q.size() == 3) begin
         x = exp_q.pop_front();
         if (x.care)
            check($sformatf("pix h=%0d v=%0d", x.h, x.v),
                  32'({r_out, g_out, b_out}), 32'(x.e));
      end
      h_cnt = 13'(h);
      v_cnt = 13'(v);
      {r_in, g_in, b_in} = rgb;
      exp_q.push_back(model_px(h, v, rgb));
   endtask

   task automatic pix_flush();
      repeat (3) pix(0, 0, 24'h0);
      exp_q.delete();
   endtask

   task automatic scan_block(int addr);
      for (int k = 0; k < 16; k++)
         pix(X0 + 4 * (addr % FB_W) + k % 4, Y0 + 4 * (addr / FB_W) + k / 4,
             24'($urandom()));
      pix_flush();
   endtask

   task automatic scan_rand(int n, int vmax);
      for (int k = 0; k < n; k++)
         pix($urandom_range(120, 800), $urandom_range(20, vmax), 24'($urandom()));
      pix_flush();
   endtask

   task automatic scan_corner();
      for (int v = 33; v <= 44; v++)
         for (int h = 142; h <= 153; h++)
            pix(h, v, 24'($urandom()));
      for (int v = 513; v <= 516; v++) begin
         pix(783, v, 24'($urandom()));
         pix(784, v, 24'($urandom()));
      end
      pix_flush();
   endtask

   task automatic wr(int addr, int data);
      tick();
      check("wr_ready", 32'(wr_ready), 1);
      wr_en = 1'b1;
      wr_addr = AW'(addr);
      wr_data = 2'(data);
      tick();
      wr_en = 1'b0;
      if (addr < DEPTH) fb_m[addr] = data;
   endtask

   task automatic pal_wr(int idx, logic [23:0] data);
      tick();
      pal_we = 1'b1;
      pal_idx = 2'(idx);
      pal_data = data;
      tick();
      pal_we = 1'b0;
      pal_m[idx] = data;
   endtask

   task automatic pal_reset_model();
      pal_m[0] = 24'h0;
      for (int i = 1; i < 4; i++) pal_m[i] = 24'hFF00FF;
   endtask

   int  busy_n, done_n, rdy_bad, hs;
   bit  drop;
   int  a_addr;

   initial begin
      rst = 1'b1;
      h_cnt = '0; v_cnt = '0;
      r_in = '0; g_in = '0; b_in = '0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      pal_we = 1'b0; pal_idx = '0; pal_data = '0;
      clr_start = 1'b0;
      for (int i = 0; i < DEPTH; i++) fb_m[i] = -1;
      pal_reset_model();

      repeat (3) tick();
      check("rst_rgb", 32'({r_out, g_out, b_out}), 0);
      check("rst_busy", 32'(clr_busy), 0);
      check("rst_done", 32'(clr_done), 0);
      check("rst_ready", 32'(wr_ready), 1);
      rst = 1'b0;

      // First clear, with a stray second start while busy
      tick();
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      busy_n = 0; done_n = 0; rdy_bad = 0;
      for (int i = 0; i < 19300; i++) begin
         if (clr_busy) begin
            busy_n++;
            if (wr_ready) rdy_bad++;
         end
         if (clr_done) done_n++;
         clr_start = (i == 50);
         tick();
      end
      clr_start = 1'b0;
      check("clr1_busy_cycles", 32'(busy_n), 19200);
      check("clr1_done_pulses", 32'(done_n), 1);
      check("clr1_ready_low", 32'(rdy_bad), 0);
      check("clr1_idle", 32'(clr_busy), 0);
      for (int i = 0; i < DEPTH; i++) fb_m[i] = 0;

      pix(144, 35, 24'h102030);
      pix(144, 35, 24'h102030);
      pix_flush();

      pal_wr(1, 24'h00FF00);
      wr(0, 1);
      wr(161, 2);
      scan_corner();

      for (int k = 0; k < 6; k++) pal_wr($urandom_range(0, 3), 24'($urandom()));
      for (int k = 0; k < 300; k++) wr($urandom_range(0, 3199), $urandom_range(0, 3));
      for (int k = 0; k < 10; k++) scan_block($urandom_range(0, 3199));
      scan_rand(400, 120);
      scan_rand(200, 530);

      // Second clear with a write request held the whole time
      pal_wr(3, 24'h3377AA);
      a_addr = $urandom_range(200, 3199);
      tick();
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      wr_en = 1'b1;
      wr_addr = AW'(a_addr);
      wr_data = 2'd3;
      busy_n = 0; done_n = 0; rdy_bad = 0; hs = 0; drop = 1'b0;
      for (int i = 0; i < 19300; i++) begin
         if (drop) wr_en = 1'b0;
         drop = 1'b0;
         if (clr_busy) begin
            busy_n++;
            if (wr_ready) rdy_bad++;
         end
         if (clr_done) done_n++;
         if (wr_en && wr_ready) begin
            hs++;
            drop = 1'b1;
         end
         tick();
      end
      wr_en = 1'b0;
      check("clr2_busy_cycles", 32'(busy_n), 19200);
      check("clr2_done_pulses", 32'(done_n), 1);
      check("clr2_ready_low", 32'(rdy_bad), 0);
      check("clr2_handshakes", 32'(hs), 1);
      for (int i = 0; i < DEPTH; i++) fb_m[i] = 0;
      fb_m[a_addr] = 3;
      scan_block(a_addr);
      scan_corner();
      scan_rand(200, 120);

      // Reset during a clear
      wr(0, 1);
      wr(161, 2);
      wr(1000, 3);
      tick();
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      repeat (100) tick();
      rst = 1'b1;
      #1;
      check("abort_rgb", 32'({r_out, g_out, b_out}), 0);
      check("abort_busy", 32'(clr_busy), 0);
      check("abort_done", 32'(clr_done), 0);
      check("abort_ready", 32'(wr_ready), 1);
      tick();
      tick();
      rst = 1'b0;
      done_n = 0; busy_n = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (clr_done) done_n++;
         if (clr_busy) busy_n++;
      end
      check("abort_no_done", 32'(done_n), 0);
      check("abort_no_busy", 32'(busy_n), 0);
      for (int i = 0; i < 95; i++) fb_m[i] = 0;
      for (int i = 95; i < 105; i++) fb_m[i] = -1;
      pal_reset_model();

      wr(20000, 1);
      scan_corner();
      scan_block(161);
      scan_block(1000);
      scan_block(a_addr);
      scan_rand(200, 120);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
